// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam int unsigned FETCH_XLEN       = 64;
  localparam int unsigned FETCH_IW         = 32;
  localparam int unsigned FETCH_IMEM_WORDS = 64;
  localparam int unsigned FETCH_RESET_PC   = 0;

  // Load counter wraps naturally at 2^32.
  function automatic logic [31:0] cnt_inc(input logic [31:0] c);
    return c + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_slot.sv
// One-entry valid/ready output register holding {inst, pc, pc4} for decode.
module fetch_slot #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned IW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [IW-1:0]   inst_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [IW-1:0]   inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            free
);

  logic            valid_q, valid_d;
  logic [IW-1:0]   inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;

  assign free  = ~valid_q | ready;
  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc    = pc_q;
  assign pc4   = pc4_q;

  // Next-slot selection: flush beats load, a consumed slot with no load empties.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      inst_d  = inst_in;
      pc_d    = pc_in;
      pc4_d   = pc_in + XLEN'(1);
    end else if (free) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC, imem address, redirects and load counter.
// Define FETCH_HALT_EN to halt at the end of instruction memory instead of wrapping.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = FETCH_XLEN,
  parameter int unsigned     IW         = FETCH_IW,
  parameter int unsigned     IMEM_WORDS = FETCH_IMEM_WORDS,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(FETCH_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [IW-1:0]   imem_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  output logic            halted,
  output logic [31:0]     fetch_cnt
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            load_s;
  logic            flush_s;
  logic            slot_free_s;

`ifdef FETCH_HALT_EN
  logic at_end_s;
  assign at_end_s  = (pc_q >= XLEN'(IMEM_WORDS));
  assign imem_addr = pc_q;
  assign halted    = (state_q == HALT);
`else
  assign imem_addr = pc_q % XLEN'(IMEM_WORDS);
  assign halted    = 1'b0;
`endif

  assign fetch_cnt = cnt_q;

  // Next-state, PC and counter; a redirect outranks everything outside IDLE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    flush_s = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          flush_s = 1'b1;
          state_d = FETCH;
        end else if (slot_free_s) begin
`ifdef FETCH_HALT_EN
          if (at_end_s) begin
            state_d = HALT;
          end else begin
            load_s = 1'b1;
            pc_d   = pc_q + XLEN'(1);
            cnt_d  = cnt_inc(cnt_q);
          end
`else
          load_s = 1'b1;
          pc_d   = pc_q + XLEN'(1);
          cnt_d  = cnt_inc(cnt_q);
`endif
        end else begin
          state_d = FETCH;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          flush_s = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  fetch_slot #(
    .XLEN (XLEN),
    .IW   (IW)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .flush   (flush_s),
    .ready   (out_ready),
    .inst_in (imem_inst),
    .pc_in   (pc_q),
    .valid   (out_valid),
    .inst    (out_inst),
    .pc      (out_pc),
    .pc4     (out_pc4),
    .free    (slot_free_s)
  );

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the instruction-fetch datapath: owns the word-addressed PC, drives the instruction-memory address, and presents each fetched instruction to decode through a one-entry valid/ready output slot. It handles backpressure, branch/jump redirects from execute, and optional halt at the end of instruction memory. It sits between the instruction memory (combinational read) and the decode stage.

## Interface
- `XLEN`, 64: PC/address width.
- `IW`, 32: instruction width.
- `IMEM_WORDS`, 64: instruction-memory depth in words.
- `RESET_PC`, 0: PC loaded at reset.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_addr`  out  XLEN  word address to instruction memory; equals `pc`.
- `imem_inst`  in  IW  instruction at `imem_addr`, same cycle.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  XLEN  redirect target (word address).
- `out_valid`  out  1  slot holds an instruction.
- `out_ready`  in  1  decode accepts the slot this cycle.
- `out_inst`  out  IW  slot instruction.
- `out_pc`  out  XLEN  address of `out_inst`.
- `out_pc4`  out  XLEN  `out_pc + 1` (next sequential word).
- `halted`  out  1  controller is in HALT.
- `fetch_cnt`  out  32  instructions loaded into the slot since reset; wraps at 2^32.

## Operation
- States: IDLE, FETCH, HALT.
- Reset (async, any time): state=IDLE, `pc`=RESET_PC, `out_valid`=0, `out_inst`/`out_pc`/`out_pc4`=0, `halted`=0, `fetch_cnt`=0.
- IDLE -> FETCH on the next edge, unconditionally; no load.
- The slot is free when `out_valid`=0 or (`out_valid` & `out_ready`).
- In FETCH, if the slot is free and there is no redirect: load the slot with `imem_inst`, set `out_pc`=`pc`, `out_pc4`=`pc+1`, set `out_valid`=1, `pc`<=`pc+1`, and increment `fetch_cnt`.
- In FETCH, if the slot is not free: hold `pc` and the slot.
- A redirect has priority over everything in FETCH or HALT:
  - `pc`<=`redirect_pc`.
  - `out_valid`<=0 (flush). A handshake in the same cycle still counts as a completed transfer.
  - No load that cycle; state<=FETCH.
- PC arithmetic is modulo 2^XLEN.
- A redirect in IDLE is ignored.

## Timing
- First instruction: edge 1 after `rst_n` rises enters FETCH; edge 2 sets `out_valid`=1 with `out_pc`=RESET_PC.
- Throughput is 1 instruction/cycle while `out_ready`=1.
- Redirect penalty: 1 bubble. Redirect at edge N; slot loads `redirect_pc` at edge N+1.
- `out_*` are registered and stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `FETCH_HALT_EN` defined:
  - In FETCH, if `pc` >= IMEM_WORDS and the slot is free (no redirect), go to HALT with no load.
  - `halted`=1 in HALT. A slot already held stays valid until consumed.
  - Only a redirect leaves HALT.
- `FETCH_HALT_EN` undefined:
  - No HALT state; `halted` is tied to 0.
  - `imem_addr` = `pc` mod IMEM_WORDS, so the PC runs past the end and memory wraps.

## Structure
- Package `fetch_pkg`:
  - State enum `fetch_state_t` {IDLE, FETCH, HALT}.
  - Default constants for XLEN, IW, IMEM_WORDS, RESET_PC.
- Sub-module `fetch_slot`: one-entry valid/ready register holding {inst, pc, pc4}, with load/flush inputs and a free output. The FSM, PC and counter stay in `fetch_controller`.

## Test plan
- Reset release with RESET_PC=0 and `out_ready`=1 -> `out_pc` = 0, 1, 2, 3 on consecutive cycles from edge 2; `fetch_cnt`=4 after 4 loads.
- `out_ready`=0 for 3 cycles with the slot holding pc=2 -> `out_pc`=2 and `out_inst` held; `pc`=3; `fetch_cnt` unchanged.
- Redirect to 7 while the slot holds pc=4 -> next cycle `out_valid`=0; the following cycle `out_pc`=7, `out_pc4`=8.
- Redirect and handshake in the same cycle -> the transfer counts, exactly one bubble, then `redirect_pc`.
- `FETCH_HALT_EN` with IMEM_WORDS=4 -> after pc=3 is loaded, `halted`=1 and `out_valid` drops once consumed; redirect to 0 resumes with `out_pc`=0. Without the macro, `imem_addr` wraps 3 -> 0.
- `rst_n` asserted mid-stream (slot valid, pc=5) -> `out_valid`=0, `pc`=RESET_PC and `fetch_cnt`=0 immediately, without waiting for a clock edge.
